pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
- Hazard and forwarding controller for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards in ID and holds PC and IF/ID for a parametrised load latency; inserts ID/EX bubbles.
- Squashes younger instructions on a taken branch resolved in EX.
- Drives EX-stage operand forwarding selects and keeps saturating stall/flush performance counters.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_LAT, 1, stall cycles per load-use hazard (1..15); covers multi-cycle data memory.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  REG_ADDR_W  source registers of the instruction in EX.
- ex_rd  in  REG_ADDR_W  destination in EX.
- ex_memread  in  1  EX instruction is a load.
- mem_rd, wb_rd  in  REG_ADDR_W  destinations in MEM/WB.
- mem_regwrite, wb_regwrite  in  1  write enables in MEM/WB.
- branch_taken  in  1  taken branch resolved in EX this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX controls (bubble).
- pc_sel  out  1  1 = take branch target.
- forward_a, forward_b  out  2  00 = register file, 10 = MEM result, 01 = WB data.
- stall_cycles, flush_events  out  CNT_W  performance counters.

Behaviour:
- Reset (synchronous, one cycle): state=RUN, stall counter=0, both perf counters=0. While reset is high: pc_write=1, if_id_write=1, flushes=0, pc_sel=0, forward_*=00.
- Load-use hazard (lu) = ex_memread & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- FSM states RUN and STALL; counter width 4.
- RUN with lu & !branch_taken:
  - Same cycle: pc_write=0, if_id_write=0, id_ex_flush=1.
  - If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; else stay in RUN.
- STALL: pc_write=0, if_id_write=0, id_ex_flush=1. cnt decrements each cycle; at cnt==1, next state is RUN. lu is not re-evaluated while in STALL. Total stall equals exactly LOAD_LAT cycles.
- branch_taken has priority over stall, in any state:
  - Same cycle: pc_sel=1, if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1.
  - Next state is RUN and cnt is cleared; a stall in progress is aborted.
- Forwarding (combinational, per operand X in {rs1, rs2}):
  - MEM match (mem_regwrite & mem_rd!=0 & mem_rd==ex_X) gives 10.
  - Otherwise WB match (same rule on WB) gives 01.
  - Otherwise 00.
  - MEM beats WB when both match. x0 is never forwarded.
- Counters:
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_events increments on every cycle with branch_taken=1.
  - Both saturate at all-ones.
  - Counters are registered, so each value is visible the cycle after the event.
- Latency: all control outputs are combinational from inputs plus current state (zero cycle). Only state, cnt and counters are registered.
- reset asserted mid-stall: state returns to RUN next cycle and pending stall cycles are discarded.

Decomposition:
- Shared package holds:
  - forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding RUN/STALL;
  - the NOP instruction constant used by IF/ID flush.
- One natural sub-module: forwarding_unit, the combinational forward_a/forward_b logic, reusable by a later ID-stage branch comparator.

Test Plan:
- LOAD_LAT=1; ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_write=0, id_ex_flush=1; stall_cycles 0->1.
- LOAD_LAT=3, same hazard -> pc_write=0 for exactly 3 cycles, then 1; stall_cycles=3.
- LOAD_LAT=3, branch_taken=1 in second stall cycle -> pc_sel=1, if_id_flush=1, pc_write=1 that cycle; RUN next cycle; stall_cycles=1, flush_events=1.
- ex_rs1=7, mem_rd=7, wb_rd=7, both regwrite=1 -> forward_a=10. Then mem_regwrite=0 -> forward_a=01. Then ex_rs1=0 with both rd=0 -> 00.
- ex_memread=1, ex_rd=0, id_rs1=0 -> no stall. id_use_rs2=0 with rs2 matching ex_rd -> no stall.
- Reset pulsed during STALL (LOAD_LAT=4) -> next cycle pc_write=1, counters=0. With CNT_W=4 and 20 stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_unit_pkg.sv
// pipeline_hazard_unit_pkg: shared forward-select codes, hazard FSM states and the pipeline NOP
package pipeline_hazard_unit_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;
endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if: pipeline <-> hazard unit bundle; master = pipeline side, slave = hazard unit
// ports: ID/EX/MEM/WB register indices and enables in, stall/flush/forward controls and perf counters out
interface pipeline_hazard_unit_if #(parameter int REG_ADDR_W = 5, parameter int CNT_W = 32);
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite, branch_taken;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel;
  logic [1:0] forward_a, forward_b;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
    output id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel,
    input  forward_a, forward_b, stall_cycles, flush_events
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
    input  id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel,
    output forward_a, forward_b, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_unit_forwarding_unit.sv
// forwarding_unit: combinational EX operand forward selects, MEM beats WB, x0 never forwarded
// ports: ex_rs1/ex_rs2, mem_rd/wb_rd with write enables in; forward_a/forward_b out
module forwarding_unit
  import pipeline_hazard_unit_pkg::*;
#(parameter int REG_ADDR_W = 5) (
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_regwrite,
  input  logic                  wb_regwrite,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
);
  logic mem_ok, wb_ok;
  always_comb begin
    mem_ok = mem_regwrite && mem_rd != '0;
    wb_ok = wb_regwrite && wb_rd != '0;
    forward_a = (mem_ok && mem_rd == ex_rs1) ? FWD_MEM : (wb_ok && wb_rd == ex_rs1) ? FWD_WB : FWD_RF;
    forward_b = (mem_ok && mem_rd == ex_rs2) ? FWD_MEM : (wb_ok && wb_rd == ex_rs2) ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: load-use stall, branch squash, EX forwarding and saturating stall/flush counters
// ports: clk, reset (sync active-high), hz (slave side of pipeline_hazard_unit_if)
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_unit_if.slave hz
);
  localparam logic [3:0] STALL_INIT = 4'(LOAD_LAT - 1);
  localparam bit MULTI = LOAD_LAT > 1;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  logic [1:0] fwd_a, fwd_b;
  logic lu, stall, br;
  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .ex_rs1(hz.ex_rs1), .ex_rs2(hz.ex_rs2), .mem_rd(hz.mem_rd), .wb_rd(hz.wb_rd),
    .mem_regwrite(hz.mem_regwrite), .wb_regwrite(hz.wb_regwrite),
    .forward_a(fwd_a), .forward_b(fwd_b)
  );
  assign lu = hz.ex_memread && hz.ex_rd != '0 &&
              ((hz.id_use_rs1 && hz.ex_rd == hz.id_rs1) || (hz.id_use_rs2 && hz.ex_rd == hz.id_rs2));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end
  // cnt holds the stall cycles still owed after the current one; a taken branch aborts them
  always_comb begin
    state_d = hz.branch_taken ? RUN : state_q == STALL ? (cnt_q == 4'd1 ? RUN : STALL) : (lu && MULTI) ? STALL : RUN;
    cnt_d = hz.branch_taken ? '0 : state_q == STALL ? cnt_q - 4'd1 : (lu && MULTI) ? STALL_INIT : '0;
    stall_cycles_d = (stall && stall_cycles_q != '1) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
    flush_events_d = (br && flush_events_q != '1) ? flush_events_q + CNT_W'(1) : flush_events_q;
  end
  always_comb begin
    br = !reset && hz.branch_taken;
    stall = !reset && !hz.branch_taken && (state_q == STALL || lu);
    hz.pc_write = !stall;
    hz.if_id_write = !stall;
    hz.if_id_flush = br;
    hz.pc_sel = br;
    hz.id_ex_flush = br || stall;
    hz.forward_a = reset ? FWD_RF : fwd_a;
    hz.forward_b = reset ? FWD_RF : fwd_b;
    hz.stall_cycles = stall_cycles_q;
    hz.flush_events = flush_events_q;
  end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed and randomized checks of three hazard units (LOAD_LAT 1/3/4)
module tb_pipeline_hazard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite, branch_taken;
  logic pcw_o [3], ifw_o [3], iff_o [3], idf_o [3], psel_o [3];
  logic [1:0] fa_o [3], fb_o [3];
  logic [31:0] sc_o [3], fe_o [3];
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int CW = (g == 2) ? 4 : 32;
    pipeline_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(CW)) bus ();
    assign bus.id_rs1 = id_rs1;
    assign bus.id_rs2 = id_rs2;
    assign bus.ex_rs1 = ex_rs1;
    assign bus.ex_rs2 = ex_rs2;
    assign bus.ex_rd = ex_rd;
    assign bus.mem_rd = mem_rd;
    assign bus.wb_rd = wb_rd;
    assign bus.id_use_rs1 = id_use_rs1;
    assign bus.id_use_rs2 = id_use_rs2;
    assign bus.ex_memread = ex_memread;
    assign bus.mem_regwrite = mem_regwrite;
    assign bus.wb_regwrite = wb_regwrite;
    assign bus.branch_taken = branch_taken;
    assign pcw_o[g] = bus.pc_write;
    assign ifw_o[g] = bus.if_id_write;
    assign iff_o[g] = bus.if_id_flush;
    assign idf_o[g] = bus.id_ex_flush;
    assign psel_o[g] = bus.pc_sel;
    assign fa_o[g] = bus.forward_a;
    assign fb_o[g] = bus.forward_b;
    assign sc_o[g] = 32'(bus.stall_cycles);
    assign fe_o[g] = 32'(bus.flush_events);
    pipeline_hazard_unit #(.REG_ADDR_W(5), .LOAD_LAT(L), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .hz(bus)
    );
  end
  function automatic int lat(int i);
    return i == 0 ? 1 : i == 1 ? 3 : 4;
  endfunction
  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel}
  function automatic logic [4:0] ctl(int i);
    return {pcw_o[i], ifw_o[i], iff_o[i], idf_o[i], psel_o[i]};
  endfunction
  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite, branch_taken} = '0;
  endtask
  task automatic hazard();
    idle();
    ex_memread = 1'b1;
    ex_rd = 5'd5;
    id_rs1 = 5'd5;
    id_use_rs1 = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    hazard();
    branch_taken = 1'b1;
    ex_rs1 = 5'd7;
    mem_rd = 5'd7;
    mem_regwrite = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b11000) begin errs++; $display("FAIL reset_ctl[%0d]: got %b want 11000", i, ctl(i)); end
      vecs++;
      if (fa_o[i] !== 2'b00) begin errs++; $display("FAIL reset_fwd[%0d]: got %b want 00", i, fa_o[i]); end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (sc_o[i] !== 0 || fe_o[i] !== 0) begin errs++; $display("FAIL reset_cnt[%0d]: got %0d/%0d want 0/0", i, sc_o[i], fe_o[i]); end
    end
    reset = 1'b0;
    idle();
  endtask
  task automatic test_load_use();
    logic s;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) hazard(); else idle();
      #1;
      for (int i = 0; i < 3; i++) begin
        s = c < lat(i);
        vecs++;
        if (ctl(i) !== {!s, !s, 1'b0, s, 1'b0}) begin errs++; $display("FAIL lu_ctl[%0d] c%0d: got %b want %b", i, c, ctl(i), {!s, !s, 1'b0, s, 1'b0}); end
        vecs++;
        if (sc_o[i] !== 32'(s ? c : lat(i))) begin errs++; $display("FAIL lu_cnt[%0d] c%0d: got %0d want %0d", i, c, sc_o[i], s ? c : lat(i)); end
      end
      tick();
    end
  endtask
  task automatic test_branch_abort();
    do_reset();
    hazard();
    #1;
    tick();
    idle();
    branch_taken = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b11111) begin errs++; $display("FAIL br_ctl[%0d]: got %b want 11111", i, ctl(i)); end
    end
    tick();
    branch_taken = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b11000) begin errs++; $display("FAIL br_after[%0d]: got %b want 11000", i, ctl(i)); end
      vecs++;
      if (sc_o[i] !== 1 || fe_o[i] !== 1) begin errs++; $display("FAIL br_cnt[%0d]: got %0d/%0d want 1/1", i, sc_o[i], fe_o[i]); end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b11000) begin errs++; $display("FAIL br_run[%0d]: got %b want 11000", i, ctl(i)); end
    end
  endtask
  task automatic test_forwarding();
    idle();
    ex_rs1 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (fa_o[i] !== 2'b10) begin errs++; $display("FAIL fwd_mem[%0d]: got %b want 10", i, fa_o[i]); end
    end
    mem_regwrite = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (fa_o[i] !== 2'b01) begin errs++; $display("FAIL fwd_wb[%0d]: got %b want 01", i, fa_o[i]); end
    end
    ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (fa_o[i] !== 2'b00) begin errs++; $display("FAIL fwd_x0[%0d]: got %b want 00", i, fa_o[i]); end
    end
    ex_rs2 = 5'd3; mem_rd = 5'd3; wb_rd = 5'd3; wb_regwrite = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if ({fa_o[i], fb_o[i]} !== 4'b0010) begin errs++; $display("FAIL fwd_b[%0d]: got %b want 0010", i, {fa_o[i], fb_o[i]}); end
    end
  endtask
  task automatic test_no_stall();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b11000) begin errs++; $display("FAIL ns_x0[%0d]: got %b want 11000", i, ctl(i)); end
    end
    ex_rd = 5'd6; id_rs1 = 5'd1; id_rs2 = 5'd6; id_use_rs2 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b11000) begin errs++; $display("FAIL ns_unused[%0d]: got %b want 11000", i, ctl(i)); end
    end
    id_use_rs2 = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b00010) begin errs++; $display("FAIL ns_rs2[%0d]: got %b want 00010", i, ctl(i)); end
    end
    ex_memread = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b11000) begin errs++; $display("FAIL ns_noload[%0d]: got %b want 11000", i, ctl(i)); end
    end
  endtask
  task automatic test_reset_mid_stall();
    do_reset();
    hazard();
    #1;
    tick();
    idle();
    tick();
    reset = 1'b1;
    #1;
    vecs++;
    if (ctl(2) !== 5'b11000) begin errs++; $display("FAIL rms_hold: got %b want 11000", ctl(2)); end
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (ctl(i) !== 5'b11000 || sc_o[i] !== 0) begin errs++; $display("FAIL rms_after[%0d]: got %b/%0d want 11000/0", i, ctl(i), sc_o[i]); end
    end
  endtask
  task automatic test_saturate();
    do_reset();
    hazard();
    repeat (20) tick();
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (sc_o[i] !== (i == 2 ? 32'd15 : 32'd20)) begin errs++; $display("FAIL sat[%0d]: got %0d want %0d", i, sc_o[i], i == 2 ? 15 : 20); end
    end
    idle();
  endtask
  task automatic test_random();
    int rem [3];
    longint msc [3], mfe [3], mx;
    logic lu, s, b;
    logic [1:0] efa, efb;
    do_reset();
    for (int i = 0; i < 3; i++) begin rem[i] = 0; msc[i] = 0; mfe[i] = 0; end
    repeat (400) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      branch_taken = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 39) == 0;
      #1;
      lu = ex_memread && ex_rd != 0 && ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
      efa = reset ? 2'b00 : ref_fwd(ex_rs1);
      efb = reset ? 2'b00 : ref_fwd(ex_rs2);
      for (int i = 0; i < 3; i++) begin
        s = !reset && !branch_taken && (rem[i] > 0 || lu);
        b = !reset && branch_taken;
        vecs++;
        if (ctl(i) !== {!s, !s, b, b || s, b}) begin errs++; $display("FAIL rnd_ctl[%0d]: got %b want %b", i, ctl(i), {!s, !s, b, b || s, b}); end
        vecs++;
        if ({fa_o[i], fb_o[i]} !== {efa, efb}) begin errs++; $display("FAIL rnd_fwd[%0d]: got %b want %b", i, {fa_o[i], fb_o[i]}, {efa, efb}); end
        vecs++;
        if (sc_o[i] !== 32'(msc[i]) || fe_o[i] !== 32'(mfe[i])) begin errs++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, sc_o[i], fe_o[i], msc[i], mfe[i]); end
        mx = i == 2 ? 15 : 64'hFFFF_FFFF;
        if (reset) begin
          rem[i] = 0; msc[i] = 0; mfe[i] = 0;
        end else begin
          if (s && msc[i] < mx) msc[i]++;
          if (b && mfe[i] < mx) mfe[i]++;
          rem[i] = b ? 0 : rem[i] > 0 ? rem[i] - 1 : s ? lat(i) - 1 : 0;
        end
      end
      tick();
    end
    reset = 1'b0;
    idle();
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_abort();
    test_forwarding();
    test_no_stall();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
